// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder that drives a wrapping grid cursor and a select key.
// Decodes E0/F0 prefixes, filters typematic repeats, and emits one-cycle move/select pulses.
module ps2_key_decoder #(
   parameter int COLS             = 4,
   parameter int ROWS             = 4,
   parameter int TYPEMATIC_FILTER = 1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] ps2_key_data,
   input  logic       ps2_key_pressed,
   input  logic       en,
   output logic [3:0] cursor_addr,
   output logic       move_pulse,
   output logic       select_pulse,
   output logic [7:0] key_code,
   output logic       key_ext
);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   localparam logic [1:0] LAST_COL = 2'(COLS - 1);
   localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

   // Held-flag / hit-vector bit positions.
   localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3, K_SEL = 4;

   state_t     r_state, w_state_nxt;
   logic       w_make, w_brk, w_ext;
   logic [4:0] w_hit;
   logic       w_accept;
   logic [4:0] r_held;
   logic [1:0] r_row, r_col;
   logic       r_move_pulse, r_select_pulse;
   logic [7:0] r_key_code;
   logic       r_key_ext;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_make      = 1'b0;
      w_brk       = 1'b0;
      w_ext       = 1'b0;
      if (ps2_key_pressed) begin
         case (r_state)
            S_IDLE: begin
               if (ps2_key_data == 8'hE0)      w_state_nxt = S_EXT;
               else if (ps2_key_data == 8'hF0) w_state_nxt = S_BRK;
               else                            w_make = 1'b1;
            end
            S_EXT: begin
               if (ps2_key_data == 8'hF0)      w_state_nxt = S_EXT_BRK;
               else if (ps2_key_data != 8'hE0) begin
                  w_make      = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_BRK, S_EXT_BRK: begin
               if (ps2_key_data != 8'hE0 && ps2_key_data != 8'hF0) begin
                  w_brk       = 1'b1;
                  w_ext       = (r_state == S_EXT_BRK);
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_hit          = '0;
      w_hit[K_UP]    = w_ext ? (ps2_key_data == 8'h75) : (ps2_key_data == 8'h1D);
      w_hit[K_DOWN]  = w_ext ? (ps2_key_data == 8'h72) : (ps2_key_data == 8'h1B);
      w_hit[K_LEFT]  = w_ext ? (ps2_key_data == 8'h6B) : (ps2_key_data == 8'h1C);
      w_hit[K_RIGHT] = w_ext ? (ps2_key_data == 8'h74) : (ps2_key_data == 8'h23);
      w_hit[K_SEL]   = !w_ext && (ps2_key_data == 8'h5A || ps2_key_data == 8'h29);
   end

   // Unmapped makes have no held flag, so they always pass the repeat filter.
   assign w_accept = w_make && en && ((TYPEMATIC_FILTER == 0) || ((w_hit & r_held) == '0));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_held         <= '0;
         r_row          <= '0;
         r_col          <= '0;
         r_move_pulse   <= 1'b0;
         r_select_pulse <= 1'b0;
         r_key_code     <= '0;
         r_key_ext      <= 1'b0;
      end else begin
         r_move_pulse   <= 1'b0;
         r_select_pulse <= 1'b0;
         if (w_make) r_held <= r_held | w_hit;
         else if (w_brk) r_held <= r_held & ~w_hit;
         if (w_accept) begin
            r_key_code     <= ps2_key_data;
            r_key_ext      <= w_ext;
            r_move_pulse   <= |w_hit[K_RIGHT:K_UP];
            r_select_pulse <= w_hit[K_SEL];
            if (w_hit[K_UP])
               r_row <= (r_row == '0) ? LAST_ROW : r_row - 2'd1;
            else if (w_hit[K_DOWN])
               r_row <= (r_row == LAST_ROW) ? '0 : r_row + 2'd1;
            else if (w_hit[K_LEFT])
               r_col <= (r_col == '0) ? LAST_COL : r_col - 2'd1;
            else if (w_hit[K_RIGHT])
               r_col <= (r_col == LAST_COL) ? '0 : r_col + 2'd1;
         end
      end
   end

   assign cursor_addr  = 4'(int'(r_row) * COLS + int'(r_col));
   assign move_pulse   = r_move_pulse;
   assign select_pulse = r_select_pulse;
   assign key_code     = r_key_code;
   assign key_ext      = r_key_ext;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table of scan bytes with hand-derived
// expected outputs, scoreboarded through a queue and compared one cycle after each strobe.
module tb_ps2_key_decoder;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] ps2_key_data = '0;
   logic       ps2_key_pressed = 1'b0;
   logic       en = 1'b0;
   logic [3:0] cursor_addr;
   logic       move_pulse, select_pulse;
   logic [7:0] key_code;
   logic       key_ext;

   int unsigned total = 0;
   int unsigned bad = 0;

   typedef struct {
      logic       en;
      logic [7:0] b;
      logic       mv;
      logic       sel;
      logic [3:0] addr;
      logic [7:0] code;
      logic       ext;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   logic strobe_d = 1'b0;

   ps2_key_decoder #(.COLS(4), .ROWS(4), .TYPEMATIC_FILTER(1)) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .ps2_key_data   (ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed),
      .en             (en),
      .cursor_addr    (cursor_addr),
      .move_pulse     (move_pulse),
      .select_pulse   (select_pulse),
      .key_code       (key_code),
      .key_ext        (key_ext)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic e, input logic [7:0] b, input logic mv, input logic sel,
                      input logic [3:0] addr, input logic [7:0] code, input logic ext);
      vec_t v;
      v.en = e; v.b = b; v.mv = mv; v.sel = sel; v.addr = addr; v.code = code; v.ext = ext;
      vecs.push_back(v);
   endtask

   // One strobe cycle followed by one idle cycle, so the idle check sees the pulse drop.
   task automatic send(input vec_t v);
      @(posedge CLOCK_50); #1;
      en              = v.en;
      ps2_key_data    = v.b;
      ps2_key_pressed = 1'b1;
      exp_q.push_back(v);
      @(posedge CLOCK_50); #1;
      ps2_key_pressed = 1'b0;
      @(posedge CLOCK_50); #1;
   endtask

   task automatic do_reset();
      @(posedge CLOCK_50); #1;
      reset = 1'b1;
      #1;
      check("rst_addr",  cursor_addr, 0);
      check("rst_move",  move_pulse, 0);
      check("rst_sel",   select_pulse, 0);
      check("rst_code",  key_code, 8'h00);
      check("rst_ext",   key_ext, 0);
      @(posedge CLOCK_50); #1;
      reset = 1'b0;
   endtask

   always @(posedge CLOCK_50) strobe_d <= ps2_key_pressed;

   always @(negedge CLOCK_50) begin
      if (strobe_d) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            check("move_pulse",   move_pulse, e.mv);
            check("select_pulse", select_pulse, e.sel);
            check("cursor_addr",  cursor_addr, e.addr);
            check("key_code",     key_code, e.code);
            check("key_ext",      key_ext, e.ext);
         end
      end else if (!reset) begin
         check("idle_pulses", {move_pulse, select_pulse}, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      // en  byte   mv sel addr code  ext
      add(1, 8'hE0, 0, 0,  0, 8'h00, 0);
      add(1, 8'h74, 1, 0,  1, 8'h74, 1);   // E0 74 -> right
      add(1, 8'hE0, 0, 0,  1, 8'h74, 1);
      add(1, 8'hF0, 0, 0,  1, 8'h74, 1);
      add(1, 8'h74, 0, 0,  1, 8'h74, 1);
      add(1, 8'h23, 1, 0,  2, 8'h23, 0);
      add(1, 8'hF0, 0, 0,  2, 8'h23, 0);
      add(1, 8'h23, 0, 0,  2, 8'h23, 0);
      add(1, 8'h23, 1, 0,  3, 8'h23, 0);
      add(1, 8'hF0, 0, 0,  3, 8'h23, 0);
      add(1, 8'h23, 0, 0,  3, 8'h23, 0);
      add(1, 8'h23, 1, 0,  0, 8'h23, 0);   // right wrap 3 -> 0
      add(1, 8'hF0, 0, 0,  0, 8'h23, 0);
      add(1, 8'h23, 0, 0,  0, 8'h23, 0);
      add(0, 8'h1B, 0, 0,  0, 8'h23, 0);   // en=0: held tracked, no move
      add(0, 8'hF0, 0, 0,  0, 8'h23, 0);
      add(0, 8'h1B, 0, 0,  0, 8'h23, 0);
      add(1, 8'h1B, 1, 0,  4, 8'h1B, 0);   // down: +4
      add(1, 8'hF0, 0, 0,  4, 8'h1B, 0);
      add(1, 8'h1B, 0, 0,  4, 8'h1B, 0);
      add(1, 8'hE0, 0, 0,  4, 8'h1B, 0);
      add(1, 8'h75, 1, 0,  0, 8'h75, 1);
      add(1, 8'hE0, 0, 0,  0, 8'h75, 1);
      add(1, 8'hF0, 0, 0,  0, 8'h75, 1);
      add(1, 8'h75, 0, 0,  0, 8'h75, 1);
      add(1, 8'hE0, 0, 0,  0, 8'h75, 1);
      add(1, 8'h75, 1, 0, 12, 8'h75, 1);   // up wrap 0 -> 12
      add(1, 8'hE0, 0, 0, 12, 8'h75, 1);
      add(1, 8'hF0, 0, 0, 12, 8'h75, 1);
      add(1, 8'h75, 0, 0, 12, 8'h75, 1);
      add(1, 8'h5A, 0, 1, 12, 8'h5A, 0);   // select
      add(1, 8'h5A, 0, 0, 12, 8'h5A, 0);   // typematic repeat filtered
      add(1, 8'h5A, 0, 0, 12, 8'h5A, 0);
      add(1, 8'hF0, 0, 0, 12, 8'h5A, 0);
      add(1, 8'h5A, 0, 0, 12, 8'h5A, 0);
      add(1, 8'h5A, 0, 1, 12, 8'h5A, 0);
      add(1, 8'hF0, 0, 0, 12, 8'h5A, 0);
      add(1, 8'h5A, 0, 0, 12, 8'h5A, 0);
      add(1, 8'hE0, 0, 0, 12, 8'h5A, 0);   // break of never-pressed key
      add(1, 8'hF0, 0, 0, 12, 8'h5A, 0);
      add(1, 8'h72, 0, 0, 12, 8'h5A, 0);
      add(1, 8'h1C, 1, 0, 15, 8'h1C, 0);   // left wrap col 0 -> 3
      add(1, 8'hF0, 0, 0, 15, 8'h1C, 0);
      add(1, 8'h1C, 0, 0, 15, 8'h1C, 0);
      add(1, 8'h16, 0, 0, 15, 8'h16, 0);   // unmapped make
      add(1, 8'hE0, 0, 0, 15, 8'h16, 0);
      add(1, 8'h5A, 0, 0, 15, 8'h5A, 1);   // E0 5A is not select
      add(1, 8'h1B, 1, 0,  3, 8'h1B, 0);   // down wrap row 3 -> 0
      add(1, 8'hF0, 0, 0,  3, 8'h1B, 0);
      add(1, 8'h1B, 0, 0,  3, 8'h1B, 0);
      add(1, 8'hE0, 0, 0,  3, 8'h1B, 0);   // E0 E0 stays extended
      add(1, 8'hE0, 0, 0,  3, 8'h1B, 0);
      add(1, 8'h74, 1, 0,  0, 8'h74, 1);
      add(1, 8'hE0, 0, 0,  0, 8'h74, 1);
      add(1, 8'hF0, 0, 0,  0, 8'h74, 1);
      add(1, 8'hE0, 0, 0,  0, 8'h74, 1);   // E0 inside E0 F0 ignored
      add(1, 8'h74, 0, 0,  0, 8'h74, 1);
      add(1, 8'hE0, 0, 0,  0, 8'h74, 1);
      add(1, 8'h74, 1, 0,  1, 8'h74, 1);

      do_reset();
      for (int i = 0; i < vecs.size(); i++) send(vecs[i]);

      // Reset after E0 discards the prefix: 75 then decodes as a plain make.
      v.en = 1; v.b = 8'hE0; v.mv = 0; v.sel = 0; v.addr = 1; v.code = 8'h74; v.ext = 1;
      send(v);
      do_reset();
      v.b = 8'h75; v.addr = 0; v.code = 8'h75; v.ext = 0;
      send(v);
      v.b = 8'hE0; send(v);
      v.b = 8'h75; v.mv = 1; v.addr = 12; v.ext = 1;
      send(v);

      repeat (2) @(posedge CLOCK_50);
      check("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter COLS, default 4, grid columns (1..4).
REQ-002 SHALL have parameter ROWS, default 4, grid rows (1..4).
REQ-003 SHALL have parameter TYPEMATIC_FILTER, default 1; 1 = ignore auto-repeat makes while key held.
REQ-004 SHALL have port CLOCK_50  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ps2_key_data  input  8  received PS/2 set-2 scan byte.
REQ-007 SHALL have port ps2_key_pressed  input  1  one-cycle strobe; ps2_key_data valid this cycle.
REQ-008 SHALL have port en  input  1  game active; gates cursor moves and pulses.
REQ-009 SHALL have port cursor_addr  output  4  tile index = row*COLS + col.
REQ-010 SHALL have port move_pulse  output  1  one-cycle pulse on accepted cursor move.
REQ-011 SHALL have port select_pulse  output  1  one-cycle pulse on accepted select key.
REQ-012 SHALL have port key_code  output  8  last accepted make code.
REQ-013 SHALL have port key_ext  output  1  last accepted make code was E0-prefixed.

Function
REQ-014 SHALL decode with 4-state FSM: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); bytes consumed only on cycles with ps2_key_pressed=1.
REQ-015 SHALL transition IDLE: E0->EXT, F0->BRK, other byte->make (non-ext), stay IDLE.
REQ-016 SHALL transition EXT: F0->EXT_BRK, E0->stay EXT, other byte->make (ext), ->IDLE.
REQ-017 SHALL transition BRK and EXT_BRK: F0 or E0 byte->stay in same state; other byte->break of that code (ext per state), ->IDLE.
REQ-018 SHALL map moves: up = E0 75 or 1D; down = E0 72 or 1B; left = E0 6B or 1C; right = E0 74 or 23; select = 5A or 29 (non-ext only).
REQ-019 SHALL keep one held flag per logical key (up, down, left, right, select), set on its make, cleared on its break.
REQ-020 SHALL accept a mapped make only if en=1 and (TYPEMATIC_FILTER=0 or held flag clear before this make).
REQ-021 SHALL, on accepted move, update cursor_addr and assert move_pulse on the clock edge that registers the final byte (one-cycle latency from strobe cycle), pulse high exactly one cycle.
REQ-022 SHALL, on accepted select, assert select_pulse one cycle with same latency; cursor_addr unchanged.
REQ-023 SHALL wrap horizontally within row: right at col COLS-1 -> col 0; left at col 0 -> col COLS-1; row unchanged.
REQ-024 SHALL wrap vertically within column: down at row ROWS-1 -> row 0; up at row 0 -> row ROWS-1.
REQ-025 SHALL update key_code/key_ext on every accepted make (mapped or unmapped, en=1); unmapped makes produce no pulse.
REQ-026 SHALL, when en=0, hold cursor_addr, key_code, key_ext, suppress pulses, but keep FSM and held flags tracking.
REQ-027 SHALL ignore break codes for unpressed keys (no error, held flags remain clear).
REQ-028 SHALL never assert move_pulse and select_pulse in same cycle.

Reset
REQ-029 SHALL, while reset=1, force FSM IDLE, all held flags 0, cursor_addr 0, move_pulse 0, select_pulse 0, key_code 8'h00, key_ext 0, independent of clock.
REQ-030 SHALL, on reset mid-sequence (e.g. after E0), discard the partial sequence; next byte decoded from IDLE.

Verification
REQ-031 SHALL cover: reset, en=1, bytes E0,74 -> cursor_addr 1, move_pulse one cycle, key_code 74, key_ext 1.
REQ-032 SHALL cover: cursor_addr 3, byte 23 -> cursor_addr 0; cursor_addr 0, E0,75 -> cursor_addr 12.
REQ-033 SHALL cover: 5A, 5A, 5A (no break), TYPEMATIC_FILTER=1 -> exactly one select_pulse; then F0,5A,5A -> second select_pulse.
REQ-034 SHALL cover: en=0, bytes 1B -> cursor_addr unchanged, no pulse; then F0,1B, en=1, 1B -> cursor_addr +4.
REQ-035 SHALL cover: E0,F0,72 break with key never pressed -> no pulse, FSM IDLE; then 1C -> left move accepted.
REQ-036 SHALL cover: E0 then reset pulse then 75 -> treated as non-ext 75, no move, key_code 75, key_ext 0.
